prio_encoder_pipe: RTL and testbench
====================================

// Module: prio_encoder_pipe
// PURPOSE
//   Parametrised, pipelined priority encoder for wide bit vectors (e.g. 128-key note-state map).
//   Reports the index of the highest or lowest set bit, selectable per sample, with valid
//   strobes and a change flag. Sits between the key/voice state registers and mono-voice
//   note selection logic; the two-stage pipeline meets 50 MHz at WIDTH=128.
// PARAMETERS
//   WIDTH  128  input vector width; must be a multiple of SEG
//   SEG    16   stage-1 segment width; power of 2, 2..WIDTH
//   IDXW   $clog2(WIDTH) (localparam)  index width; NSEG = WIDTH/SEG (localparam)
// PORTS
//   clk50M     in   1      system clock, all logic on rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      in_data/in_mode sampled this cycle
//   in_data    in   WIDTH  vector to encode
//   in_mode    in   1      0 = highest set bit wins, 1 = lowest set bit wins
//   out_valid  out  1      result valid strobe, 2 cycles after in_valid
//   out_found  out  1      1 = at least one bit of the sample was set
//   out_idx    out  IDXW   winning bit index
//   out_change out  1      pulse with out_valid when {out_found,out_idx} differs from last valid result
// BEHAVIOUR
//   - Reset: out_valid=0, out_found=0, out_idx=0, out_change=0; pipeline valids, stored
//     previous result and all stage registers cleared. Reset mid-operation discards all
//     in-flight samples; first out_valid follows the first in_valid after rst_n release by 2 cycles.
//   - Streaming, no backpressure: one sample accepted per cycle; samples never dropped or merged.
//   - Stage 1 (cycle N+1): per segment s register seg_hit[s] = |in_data[s*SEG +: SEG] and
//     seg_off[s] = local index (log2 SEG bits) of highest (mode 0) or lowest (mode 1) set bit;
//     mode and valid carried alongside.
//   - Stage 2 (cycle N+2): pick highest (mode 0) / lowest (mode 1) s with seg_hit[s];
//     out_idx = {s, seg_off[s]}; out_found = |seg_hit.
//   - Latency exactly 2 cycles, valid in -> valid out; per-sample mode honoured (mode may
//     change every cycle).
//   - Empty vector: out_found=0, out_idx=0 (see CONFIGURATION).
//   - Single bit set: both modes give same index. Bit 0 / bit WIDTH-1 boundaries exact.
//   - out_idx, out_found hold last value while out_valid=0.
//   - out_change: compared against last valid result; first valid result after reset compares
//     against reset state {0,0} (so an empty first sample gives out_change=0).
//   - Same-vector mode switch that changes index asserts out_change.
// CONFIGURATION
//   PRIO_ENC_HOLD_EN defined: on an empty sample out_idx keeps the last found index
//     (out_found=0 still reported, out_change asserts only on the found->empty transition);
//     supports mono-synth release on last note.
//   PRIO_ENC_HOLD_EN undefined: empty sample forces out_idx=0 as above.
// TESTING
//   1 reset, then in_valid=1, in_data=bit5|bit100, mode=0 -> 2 cycles later out_valid=1,
//     out_found=1, out_idx=100, out_change=1; same vector mode=1 -> out_idx=5, out_change=1.
//   2 back-to-back samples bit0, bit127, bit127, 0 (mode 0) on consecutive cycles ->
//     idx 0,127,127,0; out_change 0,1,0,1; out_found 1,1,1,0; out_valid high 4 cycles.
//   3 all-ones vector: mode 0 -> 127, mode 1 -> 0; segment-boundary bits 15/16 -> 16 (mode 0), 15 (mode 1).
//   4 assert rst_n low one cycle after an in_valid -> no out_valid ever for that sample;
//     all outputs 0 immediately (asynchronous).
//   5 PRIO_ENC_HOLD_EN defined: bit 60 then empty -> second result out_found=0, out_idx=60,
//     out_change=1; undefined: out_idx=0.
//   6 randomised vectors/modes vs reference model, WIDTH=128/SEG=16 and WIDTH=64/SEG=8 -> zero mismatches.

Source files
------------

// File: rtl/prio_encoder_pipe.sv
// Two-stage pipelined priority encoder: reports the highest or lowest set bit of in_data, chosen per sample.
// Optional macro PRIO_ENC_HOLD_EN: an empty sample keeps the last found index on out_idx.
module prio_encoder_pipe #(
    parameter int WIDTH = 128,
    parameter int SEG   = 16
) (
    input  logic                     clk50M,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    output logic                     out_found,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_change
);
    localparam int IDXW = $clog2(WIDTH);
    localparam int NSEG = WIDTH / SEG;
    localparam int OFFW = $clog2(SEG);

    logic [NSEG-1:0]           hit_c;
    logic [NSEG-1:0][OFFW-1:0] off_c;
    logic [NSEG-1:0]           s1_hit;
    logic [NSEG-1:0][OFFW-1:0] s1_off;
    logic                      s1_valid;
    logic                      s1_mode;
    logic                      found_c;
    logic [IDXW-1:0]           idx_c;

    // Stage 1: per-segment hit flag and local winner offset
    always_comb begin
        hit_c = '0;
        off_c = '0;
        for (int s = 0; s < NSEG; s++) begin
            hit_c[s] = |in_data[s*SEG +: SEG];
            if (in_mode) begin
                for (int b = SEG-1; b >= 0; b--) begin
                    if (in_data[s*SEG + b]) off_c[s] = OFFW'(b);
                end
            end else begin
                for (int b = 0; b < SEG; b++) begin
                    if (in_data[s*SEG + b]) off_c[s] = OFFW'(b);
                end
            end
        end
    end

    // Stage 2: choose the winning segment; the last match in scan order wins
    always_comb begin
        found_c = |s1_hit;
        idx_c   = '0;
        if (s1_mode) begin
            for (int s = NSEG-1; s >= 0; s--) begin
                if (s1_hit[s]) idx_c = IDXW'(s*SEG) | IDXW'(s1_off[s]);
            end
        end else begin
            for (int s = 0; s < NSEG; s++) begin
                if (s1_hit[s]) idx_c = IDXW'(s*SEG) | IDXW'(s1_off[s]);
            end
        end
`ifdef PRIO_ENC_HOLD_EN
        if (!found_c) idx_c = out_idx;
`else
        if (!found_c) idx_c = '0;
`endif
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_mode    <= 1'b0;
            s1_hit     <= '0;
            s1_off     <= '0;
            out_valid  <= 1'b0;
            out_found  <= 1'b0;
            out_idx    <= '0;
            out_change <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_hit  <= hit_c;
                s1_off  <= off_c;
                s1_mode <= in_mode;
            end
            // out_found/out_idx double as the stored previous valid result
            if (s1_valid) begin
                out_found  <= found_c;
                out_idx    <= idx_c;
                out_change <= {found_c, idx_c} != {out_found, out_idx};
            end else begin
                out_change <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed and randomised checks of prio_encoder_pipe at 128/16 and 64/8.
module tb_prio_encoder_pipe;
    logic         clk50M = 1'b0;
    logic         rst_n  = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data  = '0;
    logic         in_mode  = 1'b0;
    logic         out_valid, out_found, out_change;
    logic [6:0]   out_idx;
    logic         v64, f64, c64;
    logic [5:0]   i64;

    int cnt   = 0;
    int nfail = 0;

    prio_encoder_pipe #(.WIDTH(128), .SEG(16)) dut (
        .clk50M(clk50M), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_found(out_found),
        .out_idx(out_idx), .out_change(out_change)
    );

    prio_encoder_pipe #(.WIDTH(64), .SEG(8)) dut64 (
        .clk50M(clk50M), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[63:0]),
        .in_mode(in_mode), .out_valid(v64), .out_found(f64),
        .out_idx(i64), .out_change(c64)
    );

    always #10 clk50M = ~clk50M;

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic v, input logic f,
                       input logic [6:0] idx, input logic c);
        cmp({tag, ".valid"},  32'(out_valid),  32'(v));
        cmp({tag, ".found"},  32'(out_found),  32'(f));
        cmp({tag, ".idx"},    32'(out_idx),    32'(idx));
        cmp({tag, ".change"}, 32'(out_change), 32'(c));
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic m);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
    endtask

    // Straight full-width scan, independent of the segmented structure
    task automatic ref_enc(input logic [127:0] d, input int w, input logic m,
                           input logic [6:0] held, output logic f, output logic [6:0] idx);
        f = 1'b0;
        idx = 7'd0;
        if (m) begin
            for (int i = 0; i < w; i++)
                if (!f && d[i]) begin f = 1'b1; idx = 7'(i); end
        end else begin
            for (int i = w-1; i >= 0; i--)
                if (!f && d[i]) begin f = 1'b1; idx = 7'(i); end
        end
`ifdef PRIO_ENC_HOLD_EN
        if (!f) idx = held;
`endif
    endtask

    logic [127:0] b5_100, ones, b15_16, r;
    logic [6:0]   hold_e;
    logic         pv, pm, nv, nm, ef, ef64, pf, pf64;
    logic [127:0] pd, nd;
    logic [6:0]   ei, ei64, pi, pi64;

    initial begin
        b5_100 = '0; b5_100[5] = 1'b1; b5_100[100] = 1'b1;
        ones   = '1;
        b15_16 = '0; b15_16[15] = 1'b1; b15_16[16] = 1'b1;

        #25;
        chk("reset", 0, 0, 0, 0);
        @(negedge clk50M) rst_n = 1'b1;
        tick();

        // Same vector, both modes
        drive(1, b5_100, 0); tick();
        drive(1, b5_100, 1); tick();
        chk("t1.hi", 1, 1, 100, 1);
        drive(0, '0, 0); tick();
        chk("t1.lo", 1, 1, 5, 1);
        tick();
        chk("t1.hold", 0, 1, 5, 0);

        drive(1, 128'd1, 0); tick();
        drive(0, '0, 0); tick();
        chk("prep.b0", 1, 1, 0, 1);

        // Back-to-back boundary bits then empty
        drive(1, 128'd1, 0); tick();
        drive(1, 128'd1 << 127, 0); tick();
        chk("t2.s0", 1, 1, 0, 0);
        drive(1, 128'd1 << 127, 0); tick();
        chk("t2.s1", 1, 1, 127, 1);
        drive(1, '0, 0); tick();
        chk("t2.s2", 1, 1, 127, 0);
        drive(0, '0, 0); tick();
`ifdef PRIO_ENC_HOLD_EN
        chk("t2.s3", 1, 0, 127, 1);
`else
        chk("t2.s3", 1, 0, 0, 1);
`endif
        tick();
        cmp("t2.gap", 32'(out_valid), 32'(0));

        // All-ones and segment boundary
        drive(1, ones, 0); tick();
        drive(1, ones, 1); tick();
        chk("t3.ones.hi", 1, 1, 127, 1);
        drive(1, b15_16, 0); tick();
        chk("t3.ones.lo", 1, 1, 0, 1);
        drive(1, b15_16, 1); tick();
        chk("t3.seg.hi", 1, 1, 16, 1);
        drive(0, '0, 0); tick();
        chk("t3.seg.lo", 1, 1, 15, 1);

        // Reset with samples in flight
        drive(1, 128'd1 << 77, 0); tick();
        drive(1, 128'd1 << 33, 0); tick();
        chk("t4.pre", 1, 1, 77, 1);
        drive(0, '0, 0);
        rst_n = 1'b0;
        #1;
        chk("t4.async", 0, 0, 0, 0);
        tick();
        @(negedge clk50M) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4.flush", 0, 0, 0, 0);
        end

        // Empty first sample, then found -> empty
        drive(1, '0, 0); tick();
        drive(1, 128'd1 << 60, 1); tick();
        chk("t5.empty0", 1, 0, 0, 0);
        drive(1, '0, 1); tick();
        chk("t5.b60", 1, 1, 60, 1);
        drive(0, '0, 0); tick();
`ifdef PRIO_ENC_HOLD_EN
        chk("t5.release", 1, 0, 60, 1);
`else
        chk("t5.release", 1, 0, 0, 1);
`endif

        // Randomised stream on both widths
        rst_n = 1'b0;
        tick();
        @(negedge clk50M) rst_n = 1'b1;
        tick();
        pf = 0; pi = 0; pf64 = 0; pi64 = 0;
        pv = 0; pd = '0; pm = 0;
        for (int n = 0; n < 402; n++) begin
            nv = (n < 400) ? ($urandom_range(0, 7) != 0) : 1'b0;
            nm = 1'($urandom_range(0, 1));
            r  = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: nd = r;
                1: nd = 128'd1 << $urandom_range(0, 127);
                2: nd = '0;
                default: nd = r & {$urandom, $urandom, $urandom, $urandom}
                                & {$urandom, $urandom, $urandom, $urandom};
            endcase
            drive(nv, nd, nm);
            tick();
            cmp("rnd.valid", 32'(out_valid), 32'(pv));
            cmp("rnd64.valid", 32'(v64), 32'(pv));
            if (pv) begin
                ref_enc(pd, 128, pm, pi, ef, ei);
                ref_enc(pd, 64, pm, pi64, ef64, ei64);
                cmp("rnd.change", 32'(out_change), 32'({ef, ei} != {pf, pi}));
                cmp("rnd64.change", 32'(c64), 32'({ef64, ei64} != {pf64, pi64}));
                pf = ef; pi = ei; pf64 = ef64; pi64 = ei64;
            end else begin
                cmp("rnd.change", 32'(out_change), 32'(0));
                cmp("rnd64.change", 32'(c64), 32'(0));
            end
            cmp("rnd.found", 32'(out_found), 32'(pf));
            cmp("rnd.idx", 32'(out_idx), 32'(pi));
            cmp("rnd64.found", 32'(f64), 32'(pf64));
            cmp("rnd64.idx", 32'({1'b0, i64}), 32'(pi64));
            pv = nv; pd = nd; pm = nm;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, nfail);
        $finish;
    end
endmodule
